alu_share_arb: RTL

Two-port arbiter and sequencer that shares the single combinational ALU (op codes NOP/ADD/SUB/AND/OR/XOR/NOR) between two requesters, such as the main datapath and a future address/branch-compare helper. It grants one request at a time using round-robin priority and drives the granted operands and op onto the ALU. It registers the ALU result and returns it to the winning requester over a valid/ready response channel. The ALU itself is instantiated outside this block.

---
 rtl/alu_share_arb.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one external combinational ALU between two
// requesters and returns the registered result over a valid/ready channel.
module alu_share_arb #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic             owner_q;
  logic [WIDTH-1:0] result_p1;
  logic             grant0, grant1;
  logic             hs0, hs1;
  logic             rsp_done;

  // Grant: a lone requester wins; on a tie the one not served last wins.
  // Nothing is granted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (grant0) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (grant1) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  assign rsp_done = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (hs0 || hs1) state_d = RESP;
      RESP: if (rsp_done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage p1: capture the ALU result together with its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      result_p1 <= '0;
    end else if (state_q == IDLE && (hs0 || hs1)) begin
      last_q    <= hs1;
      owner_q   <= hs1;
      result_p1 <= alu_out;
    end
  end

  assign busy       = (state_q == RESP);
  assign rsp0_valid = busy && !owner_q;
  assign rsp1_valid = busy && owner_q;
  assign rsp0_data  = rsp0_valid ? result_p1 : '0;
  assign rsp1_data  = rsp1_valid ? result_p1 : '0;

endmodule
